// File: rtl/hud_pkg.sv
// hud_pkg: shared widths, defaults and FSM encoding for the HUD update logic.
package hud_pkg;
   localparam int BLOB_W        = 4;
   localparam int DIGIT_W       = 4;
   localparam int V_ACTIVE_DEF  = 768;
   localparam int DIGIT_MAX_DEF = 9;
   typedef enum logic [1:0] {IDLE, ARB, WRITE} state_t;
endpackage

// File: rtl/hud_update_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above start, wrapping.
module rr_pick
   import hud_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0]      req,
   input  logic [BLOB_W-1:0] start,
   output logic [BLOB_W-1:0] grant,
   output logic              valid
);
   assign valid = |req;
   // scan from the farthest offset down so the nearest request overwrites last
   always_comb begin
      grant = '0;
      for (int k = N - 1; k >= 0; k--)
         if (req[(int'(start) + k) % N]) grant = BLOB_W'((int'(start) + k) % N);
   end
endmodule

// File: rtl/hud_update_scheduler.sv
// hud_update_scheduler: per-blob decimal hit counters feeding blanking-only,
// round-robin writes into the HUD digit store.
module hud_update_scheduler
   import hud_pkg::*;
#(
   parameter int NUM_BLOBS = 8,
   parameter int V_ACTIVE  = V_ACTIVE_DEF,
   parameter int DIGIT_MAX = DIGIT_MAX_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_BLOBS-1:0] hit,
   input  logic                 clear,
   input  logic [9:0]           vcount,
   output logic                 write,
   output logic [DIGIT_W-1:0]   num,
   output logic [BLOB_W-1:0]    blob,
   output logic [NUM_BLOBS-1:0] pending,
   output logic                 busy
);
   state_t              state, state_n;
   logic [BLOB_W-1:0]   rr_ptr, grant;
   logic                valid, blank_q;
   logic [DIGIT_W-1:0]  cnt [NUM_BLOBS];
   logic [DIGIT_W-1:0]  cnt_sel;

   rr_pick #(.N(NUM_BLOBS)) u_pick (
      .req   (pending),
      .start (rr_ptr),
      .grant (grant),
      .valid (valid)
   );

   assign write = (state == WRITE);
   assign busy  = (state != IDLE);

   always_comb begin
      cnt_sel = '0;
      for (int i = 0; i < NUM_BLOBS; i++)
         if (grant == BLOB_W'(i)) cnt_sel = cnt[i];
   end

   always_comb begin
      state_n = (state == IDLE) ? ((blank_q && |pending) ? ARB : IDLE)
              : (state == ARB)  ? ((blank_q && valid) ? WRITE : IDLE)
              : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         blank_q <= 1'b0;
         rr_ptr  <= '0;
         blob    <= '0;
         num     <= '0;
      end else begin
         state   <= state_n;
         blank_q <= int'(vcount) >= V_ACTIVE;
         if (state == ARB && state_n == WRITE) begin
            blob <= grant;
            num  <= cnt_sel;
         end
         if (write) rr_ptr <= (blob == BLOB_W'(NUM_BLOBS - 1)) ? '0 : blob + 1'b1;
      end
   end

   // a hit or clear landing on the write cycle keeps the blob dirty for a rewrite
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '1;
         for (int i = 0; i < NUM_BLOBS; i++) cnt[i] <= '0;
      end else if (clear) begin
         pending <= '1;
         for (int i = 0; i < NUM_BLOBS; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BLOBS; i++) begin
            if (hit[i]) begin
               cnt[i]     <= (cnt[i] == DIGIT_W'(DIGIT_MAX)) ? '0 : cnt[i] + 1'b1;
               pending[i] <= 1'b1;
            end else if (write && blob == BLOB_W'(i)) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_hud_update_scheduler.sv
// tb_hud_update_scheduler: directed checks of counting, round-robin order,
// blanking gating, write spacing and hit/clear races.
module tb_hud_update_scheduler;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] hit = '0;
   logic       clear = 1'b0;
   logic [9:0] vcount = 10'd800;
   logic       write;
   logic [3:0] num, blob;
   logic [7:0] pending;
   logic       busy;
   int         n_checks = 0, n_fail = 0;
   int         cyc = 0, last_w = 0, gap = 0;
   logic       prev_w = 1'b0;

   hud_update_scheduler dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .hit     (hit),
      .clear   (clear),
      .vcount  (vcount),
      .write   (write),
      .num     (num),
      .blob    (blob),
      .pending (pending),
      .busy    (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (write) begin
         n_checks++;
         assert (prev_w === 1'b0) else begin
            n_fail++;
            $error("FAIL back_to_back_write: observed %0b expected 0", prev_w);
         end
      end
      prev_w = write;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_write(input logic [3:0] eb, input logic [3:0] en, input string tag);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!write && k < 20);
      check({tag, "_seen"}, 32'(write), 1);
      check({tag, "_blob"}, 32'(blob), 32'(eb));
      check({tag, "_num"}, 32'(num), 32'(en));
      gap = cyc - last_w;
      last_w = cyc;
   endtask

   task automatic no_writes(input int n, input string tag);
      int seen = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (write) seen++;
      end
      check(tag, seen, 0);
   endtask

   task automatic pulse(input logic [7:0] m);
      hit = m;
      @(negedge clk);
      hit = '0;
   endtask

   initial begin
      // reset with blanking already active
      repeat (3) @(negedge clk);
      check("rst_write", 32'(write), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_num", 32'(num), 0);
      check("rst_blob", 32'(blob), 0);
      check("rst_pending", 32'(pending), 32'hff);
      rst_n = 1'b1;
      last_w = cyc;
      for (int b = 0; b < 8; b++) begin
         wait_write(4'(b), 4'd0, "init");
         check("init_gap", gap, 3);
      end
      repeat (2) @(negedge clk);
      check("init_pending", 32'(pending), 0);
      check("init_busy", 32'(busy), 0);

      // simultaneous hits on 2 and 5, boundary line 767 vs 768
      vcount = 10'd100;
      pulse(8'h24);
      check("h25_pending", 32'(pending), 32'h24);
      vcount = 10'd767;
      no_writes(8, "h25_767_nowrite");
      vcount = 10'd768;
      wait_write(4'd2, 4'd1, "h25_a");
      wait_write(4'd5, 4'd1, "h25_b");
      check("h25_gap", gap, 3);

      // rr_ptr now 6: search wraps through 6,7,0,1 to reach 2
      vcount = 10'd100;
      pulse(8'h04);
      no_writes(4, "wrap_nowrite");
      vcount = 10'd800;
      wait_write(4'd2, 4'd2, "wrap");

      // three hits on 3 coalesce into one write
      vcount = 10'd100;
      pulse(8'h08);
      pulse(8'h08);
      pulse(8'h08);
      no_writes(4, "h3_nowrite");
      check("h3_pending", 32'(pending), 32'h08);
      vcount = 10'd800;
      wait_write(4'd3, 4'd3, "h3");
      no_writes(6, "h3_single");
      check("h3_cleared", 32'(pending), 0);

      // eleven hits on 1 wrap 9 -> 0 -> 1
      vcount = 10'd100;
      for (int k = 0; k < 11; k++) pulse(8'h02);
      vcount = 10'd800;
      wait_write(4'd1, 4'd1, "wrap9");

      // blanking drops while in ARB: abort, no write
      vcount = 10'd100;
      repeat (2) @(negedge clk);
      pulse(8'h40);
      vcount = 10'd800;
      @(negedge clk);
      vcount = 10'd0;
      @(negedge clk);
      check("abort_arb_busy", 32'(busy), 1);
      @(negedge clk);
      check("abort_idle_busy", 32'(busy), 0);
      no_writes(10, "abort_nowrite");
      check("abort_pending", 32'(pending), 32'h40);
      pulse(8'h40);
      vcount = 10'd800;
      wait_write(4'd6, 4'd2, "abort_next");

      // hit on blob 4 during its own write cycle
      vcount = 10'd100;
      pulse(8'h10);
      vcount = 10'd800;
      wait_write(4'd4, 4'd1, "race_first");
      hit = 8'h10;
      @(negedge clk);
      hit = '0;
      check("race_pending", 32'(pending), 32'h10);
      wait_write(4'd4, 4'd2, "race_second");
      check("race_gap", gap, 3);

      // clear beats hit[0]; rr_ptr is 5 so order is 5,6,7,0..4
      vcount = 10'd100;
      repeat (3) @(negedge clk);
      clear = 1'b1;
      hit = 8'h01;
      @(negedge clk);
      clear = 1'b0;
      hit = '0;
      check("clr_pending", 32'(pending), 32'hff);
      vcount = 10'd800;
      for (int k = 0; k < 8; k++) wait_write(4'((5 + k) % 8), 4'd0, "clr");
      repeat (2) @(negedge clk);
      check("end_pending", 32'(pending), 0);
      check("end_busy", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/hud_update_scheduler.md
Name: hud_update_scheduler

Overview:
- Sequences writes into the HUD digit store (`hud_digits` write/num/blob interface) from per-drum hit events.
- Keeps one decimal hit counter per blob (drum zone).
- Queues dirty blobs and round-robins between them.
- Issues at most one single-cycle write every 3 cycles, only during vertical blanking, so the HUD never changes mid-frame.

Parameters:
- NUM_BLOBS, 8, number of blob requesters (1..16; blob index is 4 bits)
- V_ACTIVE, 768, first vcount value that counts as vertical blanking
- DIGIT_MAX, 9, counter wraps from DIGIT_MAX to 0

Ports:
- clk  in  1  system clock (pixel clock domain shared with hcount/vcount)
- rst_n  in  1  asynchronous active-low reset
- hit  in  NUM_BLOBS  one-cycle hit pulse per blob; multiple bits may be set together
- clear  in  1  one-cycle pulse: zero all counters and refresh the whole HUD
- vcount  in  10  current video line
- write  out  1  one-cycle write strobe to the HUD digit store
- num  out  4  digit value for the write, valid when write=1
- blob  out  4  blob index for the write, valid when write=1
- pending  out  NUM_BLOBS  dirty flags (blob count differs from what the HUD shows)
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - write=0, num=0, blob=0, busy=0.
  - All counters=0.
  - pending=all ones, so the first blanking interval initialises the HUD to 0s.
  - rr_ptr=0, FSM=IDLE.
- Blanking flag: blank_q <= (vcount >= V_ACTIVE), registered once. All scheduling decisions use blank_q.
- Counters:
  - On hit[i], cnt[i] <= (cnt[i]==DIGIT_MAX) ? 0 : cnt[i]+1, and pending[i] <= 1.
  - The hit takes effect the cycle after the pulse.
  - Updates happen in any FSM state, independent of blanking.
  - A repeated hit on an already-pending blob coalesces: the counter still advances, and one write later shows the latest value.
- clear:
  - All cnt <= 0, pending <= all ones.
  - clear beats any hit in the same cycle; those hits are dropped.
- FSM (3 states):
  - IDLE: if blank_q and |pending, go to ARB. Otherwise stay.
  - ARB:
    - If !blank_q, return to IDLE (abort, no write).
    - Otherwise pick sel = the first set pending bit searching upward from rr_ptr, wrapping modulo NUM_BLOBS.
    - Register blob<=sel and num<=cnt[sel] (value as of this cycle). Go to WRITE.
  - WRITE:
    - write=1 for exactly this cycle. The write is committed even if blanking ends this cycle.
    - Clear pending[sel] unless hit[sel] or clear is asserted this cycle; in that case pending stays 1 and the blob is rewritten later.
    - rr_ptr <= sel+1 mod NUM_BLOBS. Go to IDLE.
- Timing:
  - Minimum 3-cycle write spacing (WRITE→IDLE→ARB→WRITE); write is never asserted in consecutive cycles.
  - Latency from vcount crossing V_ACTIVE with pending nonzero: write high 3 cycles later (blank_q reg, IDLE→ARB, ARB→WRITE).
- num/blob hold their last values outside WRITE.
- pending reflects register state, including the same-cycle set/clear priority: set wins over clear.
- A mid-operation reset aborts immediately to the reset state; any partially scheduled write is lost, but pending=all ones restores consistency.
- Width rule: the counter is 4 bits unsigned; DIGIT_MAX ≤ 15.

Decomposition:
- Shared package `hud_pkg`: localparams for FSM state encodings (IDLE/ARB/WRITE), BLOB_W=4, DIGIT_W=4, V_ACTIVE default, and DIGIT_MAX default.
- One natural sub-module: `rr_pick`. It is combinational and NUM_BLOBS-wide, takes (request vector, start pointer), and returns a grant index plus a valid flag. It is reusable by other HUD arbiters.
- Counters and FSM stay in `hud_update_scheduler`.

Test Plan:
- Reset, then hold vcount=800:
  - Expect 8 writes blob=0..7 in order, num=0, spaced 3 cycles.
  - Then pending=0, busy=0.
- vcount=100; pulse hit[3] three times; then vcount=800:
  - Exactly one write, blob=3, num=3; pending[3] clears.
- Hit[2] and hit[5] in the same cycle while vcount=100:
  - No write until blanking.
  - At vcount=768 writes go blob=2 then blob=5 (rr_ptr=0).
  - A later hit[2] with rr_ptr=6 wraps, giving a write to blob=2 after the 6/7 search.
- Hit[1] eleven times, then blanking:
  - Single write blob=1, num=1 (wrap 9→0 after the 10th hit).
- Blanking drops (vcount 800→0) on the ARB cycle:
  - No write. pending unchanged.
  - The write occurs in the next frame's blanking with the current count.
- hit[4] in the same cycle as the WRITE for blob 4:
  - Write carries the old value. pending[4] stays 1.
  - A second write to blob 4 follows with the incremented value.
- clear coincident with hit[0]:
  - All counts 0, pending=all ones.
  - The next blanking gives 8 writes of num=0.
